// File: rtl/ps2_kbd_pkg.sv
// Shared PS/2 keyboard definitions: prefix-FSM states and scancode constants.
package ps2_kbd_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_E0     = 2'd1,
    S_BRK    = 2'd2,
    S_E0_BRK = 2'd3
  } pfx_state_t;

  localparam logic [7:0] PS2_PFX_E0  = 8'hE0;
  localparam logic [7:0] PS2_PFX_E1  = 8'hE1;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
  localparam logic [7:0] XT_BRK_BIT  = 8'h80;
  localparam logic [7:0] XT_OVERRUN  = 8'hFF;

endpackage

// File: rtl/ps2_sync_fifo.sv
// Show-ahead byte FIFO: write lands on the clock edge, head visible next cycle; push when full
// is accepted only alongside a pop, otherwise ignored. ovr_en rewrites the last written slot.
module ps2_sync_fifo
  import ps2_kbd_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  input  logic       ovr_en,
  input  logic [7:0] ovr_data,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full
);

  localparam int AW = DEPTH_LOG2;
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [AW-1:0] IDX_ONE = 1;

  logic [7:0]    mem [2**AW];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          do_pop;
  logic          do_push;

  assign wr_idx  = wr_ptr[AW-1:0];
  assign rd_idx  = rd_ptr[AW-1:0];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
  assign do_pop  = rd_en && !empty;
  // When full, the popped slot is the one the new byte lands in, so push+pop is safe.
  assign do_push = wr_en && (!full || do_pop);

  assign rd_data = empty ? 8'h00 : mem[rd_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= wr_data;
    end else if (ovr_en) begin
      mem[wr_idx - IDX_ONE] <= ovr_data;
    end
  end

endmodule

// File: rtl/ps2_xt_scancode_fifo.sv
// Folds PS/2 F0 break prefixes into XT break codes (bit 7) and queues bytes; push one cycle after rx_valid.
// Full-FIFO pushes are dropped with a sticky overflow; PS2_XT_OVF_MARK_EN also marks the last slot with FF.
module ps2_xt_scancode_fifo
  import ps2_kbd_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       irq,
  output logic       overflow,
  input  logic       ovf_clr
);

  pfx_state_t state;
  logic       push_vld;
  logic [7:0] push_dat;
  logic       full;
  logic       drop;
  logic       mark_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      push_vld <= 1'b0;
      push_dat <= 8'h00;
    end else begin
      push_vld <= 1'b0;
      if (rx_valid) begin
        case (state)
          S_IDLE: begin
            if (rx_data == PS2_PFX_BRK) begin
              state <= S_BRK;
            end else begin
              push_vld <= 1'b1;
              push_dat <= rx_data;
              state    <= (rx_data == PS2_PFX_E0) ? S_E0 : S_IDLE;
            end
          end
          S_E0: begin
            if (rx_data == PS2_PFX_BRK) begin
              state <= S_E0_BRK;
            end else begin
              push_vld <= 1'b1;
              push_dat <= rx_data;
              state    <= S_IDLE;
            end
          end
          default: begin
            // S_BRK / S_E0_BRK: repeated F0 is absorbed, E0 after a bare break keeps its prefix.
            if (rx_data == PS2_PFX_BRK) begin
              state <= state;
            end else if (rx_data == PS2_PFX_E0 && state == S_BRK) begin
              push_vld <= 1'b1;
              push_dat <= PS2_PFX_E0;
              state    <= S_E0_BRK;
            end else begin
              push_vld <= 1'b1;
              push_dat <= rx_data | XT_BRK_BIT;
              state    <= S_IDLE;
            end
          end
        endcase
      end
    end
  end

  assign drop = push_vld && full && !(rd_en && !empty);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef PS2_XT_OVF_MARK_EN
  logic mark_done;

  assign mark_en = drop && !mark_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mark_done <= 1'b0;
    end else if (rd_en && !empty) begin
      mark_done <= 1'b0;
    end else if (mark_en) begin
      mark_done <= 1'b1;
    end
  end
`else
  assign mark_en = 1'b0;
`endif

  ps2_sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (push_vld),
    .wr_data  (push_dat),
    .rd_en    (rd_en),
    .ovr_en   (mark_en),
    .ovr_data (XT_OVERRUN),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full)
  );

  assign irq = ~empty;

endmodule

// File: tb/tb_ps2_xt_scancode_fifo.sv
// Scoreboard bench for ps2_xt_scancode_fifo at DEPTH_LOG2=2; inputs change and outputs are sampled on negedge.
module tb_ps2_xt_scancode_fifo;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       empty;
  logic       irq;
  logic       overflow;
  logic       ovf_clr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  ps2_xt_scancode_fifo #(.DEPTH_LOG2(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .irq      (irq),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  task automatic pop_chk(input string tag);
    int n = 0;
    logic [7:0] e;
    while (empty && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (empty) chk({tag, "_timeout"}, 16'(empty), 16'd0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
    chk(tag, 16'(rd_data), 16'(e));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;

    // Reset state
    idle(2);
    chk("rst_rd_data", 16'(rd_data), 16'h00);
    chk("rst_empty", 16'(empty), 16'd1);
    chk("rst_irq", 16'(irq), 16'd0);
    chk("rst_ovf", 16'(overflow), 16'd0);
    reset_n = 1'b1;
    idle(2);

    // Make / break
    send(8'h1E); expect_byte(8'h1E);
    send(8'hF0);
    send(8'h1E); expect_byte(8'h9E);
    idle(2);
    chk("mb_irq_set", 16'(irq), 16'd1);
    pop_chk("mb_make");
    pop_chk("mb_break");
    chk("mb_empty", 16'(empty), 16'd1);
    chk("mb_irq_clr", 16'(irq), 16'd0);

    // Extended make / break; E1 passes through verbatim
    send(8'hE0); expect_byte(8'hE0);
    send(8'h1D); expect_byte(8'h1D);
    pop_chk("ext_e0_a");
    pop_chk("ext_make");
    send(8'hE0); expect_byte(8'hE0);
    send(8'hF0);
    send(8'h1D); expect_byte(8'h9D);
    send(8'hE1); expect_byte(8'hE1);
    pop_chk("ext_e0_b");
    pop_chk("ext_break");
    pop_chk("ext_e1");
    chk("ext_empty", 16'(empty), 16'd1);

    // Overflow with no reads
    for (int i = 1; i <= 5; i++) send(8'(i));
    expect_byte(8'h01); expect_byte(8'h02); expect_byte(8'h03);
`ifdef PS2_XT_OVF_MARK_EN
    expect_byte(8'hFF);
`else
    expect_byte(8'h04);
`endif
    idle(2);
    chk("ovf_set", 16'(overflow), 16'd1);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    chk("ovf_clr", 16'(overflow), 16'd0);
    // A new drop landing in the same cycle as ovf_clr leaves overflow set
    @(negedge clk); rx_data = 8'h06; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0; ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    chk("ovf_clr_race", 16'(overflow), 16'd1);
    for (int i = 0; i < 4; i++) pop_chk("ovf_data");
    chk("ovf_empty", 16'(empty), 16'd1);
    chk("ovf_sticky", 16'(overflow), 16'd1);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    chk("ovf_clr2", 16'(overflow), 16'd0);

    // Simultaneous push and pop while full
    for (int i = 0; i < 4; i++) begin
      send(8'hA1 + 8'(i));
      expect_byte(8'hA1 + 8'(i));
    end
    expect_byte(8'hA5);
    idle(2);
    @(negedge clk); rx_data = 8'hA5; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    chk("pp_head", 16'(rd_data), 16'(exp_q.pop_front()));
    rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    chk("pp_no_ovf", 16'(overflow), 16'd0);
    for (int i = 0; i < 4; i++) pop_chk("pp_order");
    chk("pp_count4", 16'(empty), 16'd1);

    // Reset during a pending break
    send(8'hF0);
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_empty", 16'(empty), 16'd1);
    reset_n = 1'b1;
    idle(1);
    send(8'h1E); expect_byte(8'h1E);
    pop_chk("mid_rst_make");
    idle(1);
    chk("mid_rst_empty2", 16'(empty), 16'd1);

    // Pointer wrap
    for (int i = 0; i < 40; i++) begin
      b = 8'h10 + 8'(i);
      send(b); expect_byte(b);
      @(negedge clk);
      chk("wrap_nonempty", 16'(empty), 16'd0);
      pop_chk("wrap_data");
      chk("wrap_empty", 16'(empty), 16'd1);
    end
    chk("sb_drained", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
